// File: rtl/verifier_io_pkg.sv
// Shared types and field helpers for the verifier io banks.
// Field width and modulus default to a 16-bit prime unless the build defines them.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

package verifier_io_pkg;
  localparam int F_NBITS = `F_NBITS;

  typedef logic [`F_NBITS-1:0] felem_t;

  localparam felem_t F_Q = felem_t'(`F_Q);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} fsm_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic felem_t f_mul(input felem_t a, input felem_t b);
    logic [2*F_NBITS-1:0] prod;
    prod = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    return felem_t'(prod % {{F_NBITS{1'b0}}, F_Q});
  endfunction

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic felem_t f_add(input felem_t a, input felem_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction
endpackage

// File: rtl/verifier_compute_io_fold_lane.sv
// One fold lane: out = m_tau_p1*even + tau*odd mod p, done pulses after 1..8 cycles.
// Latency is drawn from a per-lane LFSR so the bank never relies on a fixed lane timing.
module verifier_compute_io_fold_lane
  import verifier_io_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   en,
  input  logic   restart,
  input  felem_t even,
  input  felem_t odd,
  input  felem_t tau,
  input  felem_t m_tau_p1,
  output felem_t out,
  output logic   done
);
  localparam logic [7:0] LFSR_SEED = 8'hA5 + 8'(LANE_ID * 29);

  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  felem_t     res_q, res_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cnt_d  = cnt_q;
    busy_d = busy_q;
    res_d  = res_q;
    done_d = 1'b0;
    if (restart) begin
      busy_d = 1'b0;
    end else if (en) begin
      res_d  = f_add(f_mul(m_tau_p1, even), f_mul(tau, odd));
      cnt_d  = lfsr_q[2:0];
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == 3'd0) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lfsr_q <= LFSR_SEED;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign out  = res_q;
  assign done = done_q;
endmodule

// File: rtl/verifier_compute_io_mlbank.sv
// Multilinear-extension bank: folds 2^L latched copies LSB-first over tau using shared lanes.
// Result handshake: out_valid holds out_val stable until a cycle with out_ready high (abort wins).
module verifier_compute_io_mlbank
  import verifier_io_pkg::*;
#(
  parameter  int nCopyBits = 3,
  parameter  int nParBits  = 1,
  localparam int nCopies   = 1 << nCopyBits,
  localparam int nParallel = 1 << nParBits,
  localparam int LW        = clog2(nCopyBits + 1),
  localparam int CW        = nCopyBits + 1
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LW-1:0]              log_copies,
  input  felem_t [nCopyBits-1:0]     tau,
  input  felem_t [nCopyBits-1:0]     m_tau_p1,
  input  felem_t [nCopies-1:0]       in_vals,
  output felem_t                     out_val,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       err,
  output fsm_state_t                 dbg_state,
  output logic [LW-1:0]              dbg_round
);
  fsm_state_t              state_q, state_d;
  logic [LW-1:0]           lc_q, lc_d, round_q, round_d, round_nx;
  felem_t [nCopyBits-1:0]  tau_q, tau_d, mt_q, mt_d;
  felem_t [nCopies-1:0]    buf_q, buf_d;
  logic [CW-1:0]           base_q, base_d, base_nx;
  logic [nParallel-1:0]    mask_q, mask_d, seen_q, seen_d;
  felem_t [nParallel-1:0]  res_q, res_d;
  felem_t                  out_val_q, out_val_d;
  logic                    out_valid_q, out_valid_d, busy_q, busy_d, err_q, err_d;

  logic [CW-1:0]           pairs_r, remaining, n_issue, pidx;
  logic [nParallel-1:0]    issue_mask, lane_en, lane_done;
  logic                    lane_restart;
  logic [nCopyBits-1:0]    wi;
  felem_t                  cur_tau, cur_mt;
  felem_t                  lane_even [nParallel];
  felem_t                  lane_odd  [nParallel];
  felem_t                  lane_out  [nParallel];

  // Round/batch bookkeeping and lane operand selection for the current batch.
  always_comb begin
    pairs_r   = CW'(1) << (lc_q - LW'(1) - round_q);
    remaining = pairs_r - base_q;
    n_issue   = (remaining < CW'(nParallel)) ? remaining : CW'(nParallel);
    cur_tau   = '0;
    cur_mt    = '0;
    pidx      = '0;
    for (int r = 0; r < nCopyBits; r++) begin
      if (round_q == LW'(r)) begin
        cur_tau = tau_q[r];
        cur_mt  = mt_q[r];
      end
    end
    for (int j = 0; j < nParallel; j++) begin
      issue_mask[j] = CW'(j) < n_issue;
      pidx          = base_q + CW'(j);
      lane_even[j]  = buf_q[nCopyBits'({pidx, 1'b0})];
      lane_odd[j]   = buf_q[nCopyBits'({pidx, 1'b1})];
    end
  end

  for (genvar g = 0; g < nParallel; g++) begin : g_lane
    verifier_compute_io_fold_lane #(.LANE_ID(g)) u_lane (
      .clk      (clk),
      .rstb     (rstb),
      .en       (lane_en[g]),
      .restart  (lane_restart),
      .even     (lane_even[g]),
      .odd      (lane_odd[g]),
      .tau      (cur_tau),
      .m_tau_p1 (cur_mt),
      .out      (lane_out[g]),
      .done     (lane_done[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    lc_d         = lc_q;
    tau_d        = tau_q;
    mt_d         = mt_q;
    buf_d        = buf_q;
    round_d      = round_q;
    base_d       = base_q;
    mask_d       = mask_q;
    seen_d       = seen_q;
    res_d        = res_q;
    out_val_d    = out_val_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    err_d        = err_q;
    lane_en      = '0;
    lane_restart = 1'b0;
    wi           = '0;
    base_nx      = base_q + CW'(nParallel);
    round_nx     = round_q + LW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        lc_d    = log_copies;
        tau_d   = tau;
        mt_d    = m_tau_p1;
        buf_d   = in_vals;
        round_d = '0;
        base_d  = '0;
        busy_d  = 1'b1;
        err_d   = 1'b0;
      end
      LOAD: begin
        if (lc_q == '0) begin
          state_d     = DONE;
          out_val_d   = buf_q[0];
          out_valid_d = 1'b1;
        end else if (lc_q > LW'(nCopyBits)) begin
          state_d     = DONE;
          out_val_d   = '0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lane_en = issue_mask;
        mask_d  = issue_mask;
        seen_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        for (int j = 0; j < nParallel; j++) begin
          if (lane_done[j] && mask_q[j]) begin
            seen_d[j] = 1'b1;
            res_d[j]  = lane_out[j];
          end
        end
        // Batch writes land at indices below any pair still to be read this round.
        if ((seen_q & mask_q) == mask_q) begin
          for (int j = 0; j < nParallel; j++) begin
            if (mask_q[j]) begin
              wi        = nCopyBits'(base_q + CW'(j));
              buf_d[wi] = res_q[j];
            end
          end
          if (base_nx >= pairs_r) begin
            base_d  = '0;
            round_d = round_nx;
            if (round_nx == lc_q) begin
              state_d     = DONE;
              out_val_d   = buf_d[0];
              out_valid_d = 1'b1;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            base_d  = base_nx;
            state_d = ISSUE;
          end
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d      = IDLE;
      out_valid_d  = 1'b0;
      busy_d       = 1'b0;
      lane_restart = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      lc_q        <= '0;
      tau_q       <= '0;
      mt_q        <= '0;
      buf_q       <= '0;
      round_q     <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      seen_q      <= '0;
      res_q       <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lc_q        <= lc_d;
      tau_q       <= tau_d;
      mt_q        <= mt_d;
      buf_q       <= buf_d;
      round_q     <= round_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
      seen_q      <= seen_d;
      res_q       <= res_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_round = round_q;
endmodule

// File: tb/tb_verifier_compute_io_mlbank.sv
// Bench for the MLE bank: random runs scored against a direct sum-of-weighted-copies model,
// plus directed vectors, handshake hold, abort and mid-run reset scenarios.
module tb_verifier_compute_io_mlbank;
  import verifier_io_pkg::*;

  localparam int NCB = 4;
  localparam int NPB = 2;
  localparam int NC  = 1 << NCB;
  localparam int LW  = $clog2(NCB + 1);
  localparam int W   = F_NBITS + 1;

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                out_ready = 1'b0;
  logic [LW-1:0]       log_copies = '0;
  felem_t [NCB-1:0]    tau = '0;
  felem_t [NCB-1:0]    m_tau_p1 = '0;
  felem_t [NC-1:0]     in_vals = '0;
  felem_t              out_val;
  logic                out_valid, busy, err;
  fsm_state_t          dbg_state;
  logic [LW-1:0]       dbg_round;

  logic [W-1:0]        exp_q[$];
  logic [W-1:0]        mon_e;
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  ready_mode = 0;
  int                  issue_cnt[NCB];

  felem_t [NC-1:0]     tv;
  felem_t [NCB-1:0]    tt, tm;

  // clock / reset
  always #5 clk = ~clk;

  verifier_compute_io_mlbank #(.nCopyBits(NCB), .nParBits(NPB)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .abort      (abort),
    .log_copies (log_copies),
    .tau        (tau),
    .m_tau_p1   (m_tau_p1),
    .in_vals    (in_vals),
    .out_val    (out_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state),
    .dbg_round  (dbg_round)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MLE = sum_i v[i] * prod_r (bit r of i ? tau[r] : 1-tau[r]).
  function automatic felem_t mle(input int l, input felem_t [NC-1:0] v,
                                 input felem_t [NCB-1:0] t, input felem_t [NCB-1:0] m);
    longint p, acc, w, f;
    p = longint'(F_Q);
    acc = 0;
    for (int i = 0; i < (1 << l); i++) begin
      w = longint'(v[i]);
      for (int r = 0; r < l; r++) begin
        f = ((i >> r) & 1) ? longint'(t[r]) : longint'(m[r]);
        w = (w * f) % p;
      end
      acc = (acc + w) % p;
    end
    return felem_t'(acc);
  endfunction

  function automatic felem_t rnd();
    return felem_t'($urandom_range(0, int'(F_Q) - 1));
  endfunction

  task automatic randomize_vec();
    for (int i = 0; i < NC; i++) tv[i] = rnd();
    for (int r = 0; r < NCB; r++) begin
      tt[r] = rnd();
      tm[r] = ($urandom_range(0, 3) == 0) ? rnd() : felem_t'((int'(F_Q) + 1 - int'(tt[r])) % int'(F_Q));
    end
  endtask

  // driver: pulse start for one cycle, then scramble inputs to prove they were latched
  task automatic issue(input int l, input bit push_model);
    @(posedge clk); #2;
    log_copies = LW'(l);
    in_vals = tv;
    tau = tt;
    m_tau_p1 = tm;
    start = 1'b1;
    if (push_model) begin
      if (l > NCB) exp_q.push_back({1'b1, felem_t'(0)});
      else exp_q.push_back({1'b0, mle(l, tv, tt, tm)});
    end
    @(posedge clk); #2;
    start = 1'b0;
    check("start_busy", busy, 1);
    for (int i = 0; i < NC; i++) in_vals[i] = rnd();
    for (int r = 0; r < NCB; r++) begin
      tau[r] = rnd();
      m_tau_p1[r] = rnd();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #2;
      if (!busy) break;
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_wait_r1();
    int  n;
    bit  found;
    n = 0;
    found = 0;
    while (n < 500 && !found) begin
      @(posedge clk); #2;
      if (dbg_state == WAIT && dbg_round == LW'(1)) found = 1;
      n++;
    end
    check("reach_wait_round1", found, 1);
  endtask

  // consumer ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // scoreboard monitor: one comparison per accepted result
  always @(negedge clk) begin
    if (rstb && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got val %0d err %0d with no expected entry", out_val, err);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_val", out_val, mon_e[F_NBITS-1:0]);
        check("result_err", err, mon_e[F_NBITS]);
      end
    end
  end

  always @(negedge clk) begin
    if (rstb && dbg_state == ISSUE && int'(dbg_round) < NCB) issue_cnt[int'(dbg_round)]++;
  end

  initial begin
    felem_t held;
    int     n;
    bit     stable, quiet;

    repeat (3) @(posedge clk);
    #2;
    check("reset_out_val", out_val, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rstb = 1'b1;

    // directed fold: expected 9
    randomize_vec();
    tv[0] = 1; tv[1] = 2; tv[2] = 3; tv[3] = 4;
    tt[0] = 2; tt[1] = 3;
    tm[0] = F_Q - felem_t'(1); tm[1] = F_Q - felem_t'(2);
    exp_q.push_back({1'b0, felem_t'(9)});
    issue(2, 0);
    wait_idle("t1_done");

    // tau all 0 selects copy 0, tau all 1 selects copy 3
    tv[0] = 7; tv[1] = 8; tv[2] = 9; tv[3] = 10;
    for (int r = 0; r < NCB; r++) begin tt[r] = 0; tm[r] = 1; end
    exp_q.push_back({1'b0, felem_t'(7)});
    issue(2, 0);
    wait_idle("t2a_done");
    for (int r = 0; r < NCB; r++) begin tt[r] = 1; tm[r] = 0; end
    exp_q.push_back({1'b0, felem_t'(10)});
    issue(2, 0);
    wait_idle("t2b_done");

    // L=0: out_valid two cycles after start
    @(posedge clk); #2;
    log_copies = '0;
    in_vals[0] = 42;
    start = 1'b1;
    exp_q.push_back({1'b0, felem_t'(42)});
    @(posedge clk); #2;
    start = 1'b0;
    in_vals[0] = 5;
    check("l0_valid_after_1", out_valid, 0);
    @(posedge clk); #2;
    check("l0_valid_after_2", out_valid, 1);
    wait_idle("t3a_done");

    // L beyond range flags err, next good run clears it
    randomize_vec();
    issue(NCB + 1, 1);
    wait_idle("t3b_done");
    randomize_vec();
    issue(1, 1);
    wait_idle("t3c_done");

    // full-width run with batch counting
    for (int r = 0; r < NCB; r++) issue_cnt[r] = 0;
    randomize_vec();
    issue(4, 1);
    wait_idle("t4_done");
    check("batches_r0", issue_cnt[0], 2);
    check("batches_r1", issue_cnt[1], 1);
    check("batches_r2", issue_cnt[2], 1);
    check("batches_r3", issue_cnt[3], 1);

    // hold out_ready low: value stable, stray starts ignored
    ready_mode = 1;
    randomize_vec();
    issue(3, 1);
    n = 0;
    while (n < 2000 && !out_valid) begin @(posedge clk); #2; n++; end
    check("hold_valid_seen", out_valid, 1);
    held = out_val;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (out_val !== held || out_valid !== 1'b1) stable = 0;
      start = (i == 4 || i == 11);
      log_copies = '0;
    end
    start = 1'b0;
    check("hold_stable", stable, 1);
    check("hold_state_done", 32'(dbg_state), 32'(DONE));
    @(posedge clk); #2;
    ready_mode = 2;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    ready_mode = 0;
    check("accept_start_ignored_busy", busy, 0);
    check("accept_start_ignored_valid", out_valid, 0);
    randomize_vec();
    issue(3, 1);
    wait_idle("t5_next_done");

    // abort mid-WAIT in round 1
    randomize_vec();
    issue(4, 0);
    wait_wait_r1();
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    quiet = 1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #2;
      if (out_valid || busy) quiet = 0;
    end
    check("abort_quiet", quiet, 1);
    randomize_vec();
    issue(4, 1);
    wait_idle("t6a_done");

    // asynchronous reset mid-run
    randomize_vec();
    issue(4, 0);
    wait_wait_r1();
    rstb = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_val", out_val, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #2;
    rstb = 1'b1;
    randomize_vec();
    issue(4, 1);
    wait_idle("t6b_done");

    // random runs
    for (int k = 0; k < 14; k++) begin
      randomize_vec();
      issue($urandom_range(0, NCB), 1);
      wait_idle("rand_done");
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
